// File: rtl/fir_mac_seq.sv
// fir_mac_seq: sequential multiply-accumulate FIR stage with a writable
// coefficient bank and one shared multiplier.
// Samples and coefficients are signed Q(mag).(pres) words, largo+1 bits wide.
// The accumulator is wider than a full product so that TAPS products can be
// summed without wrapping before the result is saturated.
// Optional build macro: FIR_ROUND_EN adds round-half-up before the final
// right shift. When it is left undefined the shift truncates toward minus
// infinity.
module fir_mac_seq #(
   parameter int largo = 22,
   parameter int mag   = 8,
   parameter int pres  = 14,
   parameter int TAPS  = 5,
   parameter int AW    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic signed [largo:0]   sample_i,
   input  logic                    sample_vld_i,
   input  logic signed [largo:0]   coef_i,
   input  logic [AW-1:0]           coef_addr_i,
   input  logic                    coef_we_i,
   output logic signed [largo:0]   y_o,
   output logic                    y_vld_o,
   output logic                    busy_o,
   output logic                    ovr_o,
   output logic                    sat_o
);

   localparam int W    = largo + 1;
   localparam int PW   = 2 * W;
   localparam int ACCW = PW + AW;

   // Saturation bounds and rounding constant at accumulator width.
   localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACCW-1:0] YMIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [ACCW-1:0] RND  = {{(ACCW-pres){1'b0}}, 1'b1, {(pres-1){1'b0}}};

   // The sign/integer/fraction split has to add up to the word width.
   if (1 + mag + pres != W || TAPS < 2 || TAPS > 16 || TAPS > (2 ** AW)) begin : g_param_check
      $error("fir_mac_seq: inconsistent parameters");
   end

   typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;

   state_t                  state;
   state_t                  state_next;
   logic signed [W-1:0]     taps  [TAPS];
   logic signed [W-1:0]     coefs [TAPS];
   logic signed [W-1:0]     cap;
   logic [AW-1:0]           k;
   logic signed [ACCW-1:0]  acc;
   logic                    busy;

   logic signed [W-1:0]     tap_sel;
   logic signed [W-1:0]     coef_sel;
   logic signed [PW-1:0]    prod;
   logic signed [ACCW-1:0]  prod_ext;
   logic signed [ACCW-1:0]  acc_rnd;
   logic signed [ACCW-1:0]  shifted;
   logic signed [W-1:0]     y_next;
   logic                    sat_next;
   logic                    coef_wr_ok;

   assign busy_o = busy;

   // A coefficient write lands only while idle and only on a real tap.
   assign coef_wr_ok = coef_we_i && (state == IDLE) &&
                       ({1'b0, coef_addr_i} < (AW+1)'(TAPS));

   // State register.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: IDLE -> SHIFT -> MAC (TAPS cycles) -> OUT -> IDLE.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = sample_vld_i ? SHIFT : IDLE;
         SHIFT:   state_next = MAC;
         MAC:     state_next = (k == AW'(TAPS - 1)) ? OUT : MAC;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Operand select for the shared multiplier: tap k times coefficient k.
   always_comb begin
      tap_sel  = '0;
      coef_sel = '0;
      for (int i = 0; i < TAPS; i++) begin
         tap_sel  = (k == AW'(i)) ? taps[i]  : tap_sel;
         coef_sel = (k == AW'(i)) ? coefs[i] : coef_sel;
      end
      prod     = PW'(tap_sel) * PW'(coef_sel);
      prod_ext = ACCW'(prod);
   end

   // Rescale the accumulator back to the sample format and clamp it.
   always_comb begin
`ifdef FIR_ROUND_EN
      acc_rnd = acc + RND;
`else
      acc_rnd = acc;
`endif
      shifted = acc_rnd >>> pres;
      if (shifted > YMAX) begin
         y_next   = YMAX[W-1:0];
         sat_next = 1'b1;
      end else if (shifted < YMIN) begin
         y_next   = YMIN[W-1:0];
         sat_next = 1'b1;
      end else begin
         y_next   = shifted[W-1:0];
         sat_next = 1'b0;
      end
   end

   // Datapath: capture, delay line, coefficient bank, accumulate, output.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < TAPS; i++) begin
            taps[i]  <= '0;
            coefs[i] <= '0;
         end
         cap     <= '0;
         k       <= '0;
         acc     <= '0;
         busy    <= 1'b0;
         y_o     <= '0;
         y_vld_o <= 1'b0;
         ovr_o   <= 1'b0;
         sat_o   <= 1'b0;
      end else begin
         y_vld_o <= 1'b0;
         sat_o   <= 1'b0;
         busy    <= (state_next != IDLE);
         // A strobe that arrives while busy is dropped and remembered.
         if (sample_vld_i && busy) begin
            ovr_o <= 1'b1;
         end
         for (int i = 0; i < TAPS; i++) begin
            if (coef_wr_ok && (coef_addr_i == AW'(i))) begin
               coefs[i] <= coef_i;
            end
         end
         case (state)
            IDLE: begin
               if (sample_vld_i) begin
                  cap <= sample_i;
               end
            end
            SHIFT: begin
               taps[0] <= cap;
               for (int i = 1; i < TAPS; i++) begin
                  taps[i] <= taps[i-1];
               end
               acc <= '0;
               k   <= '0;
            end
            MAC: begin
               acc <= acc + prod_ext;
               k   <= k + AW'(1);
            end
            OUT: begin
               y_o     <= y_next;
               y_vld_o <= 1'b1;
               sat_o   <= sat_next;
            end
            default: begin
               k <= '0;
            end
         endcase
      end
   end

endmodule
